// File: rtl/rop_frag_queue.sv
// ROP fragment request queue: buffers DEPTH multi-lane batches and re-issues them as
// OUT_LANES-wide non-empty groups. Optional perf counters: define ROP_FRAG_QUEUE_PERF_EN.
module rop_frag_queue #(
    parameter int NUM_LANES = 4,
    parameter int OUT_LANES = 1,
    parameter int DEPTH     = 4,
    parameter int DIM_BITS  = 11,
    parameter int ZBITS     = 24
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            valid_in,
    output logic                            ready_in,
    input  logic [NUM_LANES-1:0]            tmask_in,
    input  logic [NUM_LANES*DIM_BITS-1:0]   pos_x_in,
    input  logic [NUM_LANES*DIM_BITS-1:0]   pos_y_in,
    input  logic [NUM_LANES*32-1:0]         color_in,
    input  logic [NUM_LANES*ZBITS-1:0]      depth_in,
    input  logic [NUM_LANES-1:0]            backface_in,
    output logic                            valid_out,
    input  logic                            ready_out,
    output logic [OUT_LANES-1:0]            tmask_out,
    output logic [OUT_LANES*DIM_BITS-1:0]   pos_x_out,
    output logic [OUT_LANES*DIM_BITS-1:0]   pos_y_out,
    output logic [OUT_LANES*32-1:0]         color_out,
    output logic [OUT_LANES*ZBITS-1:0]      depth_out,
    output logic [OUT_LANES-1:0]            backface_out,
    output logic                            last_out,
`ifdef ROP_FRAG_QUEUE_PERF_EN
    output logic [31:0]                     perf_stalls,
    output logic [31:0]                     perf_drops,
`endif
    output logic [$clog2(DEPTH):0]          count
);

    localparam int NG = NUM_LANES / OUT_LANES;
    localparam int AW = $clog2(DEPTH);
    localparam int GW = (NG > 1) ? $clog2(NG) : 1;

    logic [NUM_LANES-1:0]          mask_mem [DEPTH];
    logic [NUM_LANES*DIM_BITS-1:0] x_mem    [DEPTH];
    logic [NUM_LANES*DIM_BITS-1:0] y_mem    [DEPTH];
    logic [NUM_LANES*32-1:0]       c_mem    [DEPTH];
    logic [NUM_LANES*ZBITS-1:0]    z_mem    [DEPTH];
    logic [NUM_LANES-1:0]          bf_mem   [DEPTH];

    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [GW-1:0]        grp_ptr, sel;
    logic [NUM_LANES-1:0] head_mask;
    logic [NG-1:0]        grp_nz;
    logic                 push, pop, fire, found;

    assign ready_in  = (count != (AW+1)'(DEPTH));
    assign valid_out = (count != '0);
    assign push      = valid_in && ready_in && (|tmask_in);
    assign fire      = valid_out && ready_out;
    assign pop       = fire && last_out;
    assign head_mask = mask_mem[rd_ptr];

    genvar g;
    for (g = 0; g < NG; g++) begin : g_grp
        assign grp_nz[g] = |head_mask[g*OUT_LANES +: OUT_LANES];
    end

    // sel: first non-empty group at or after grp_ptr; any further non-empty group clears last
    always_comb begin
        sel      = '0;
        found    = 1'b0;
        last_out = 1'b1;
        for (int i = 0; i < NG; i++) begin
            if (grp_nz[i] && (i >= int'(grp_ptr))) begin
                if (!found) begin
                    sel   = GW'(i);
                    found = 1'b1;
                end else begin
                    last_out = 1'b0;
                end
            end
        end
    end

    assign tmask_out    = head_mask[int'(sel)*OUT_LANES +: OUT_LANES];
    assign pos_x_out    = x_mem[rd_ptr][int'(sel)*OUT_LANES*DIM_BITS +: OUT_LANES*DIM_BITS];
    assign pos_y_out    = y_mem[rd_ptr][int'(sel)*OUT_LANES*DIM_BITS +: OUT_LANES*DIM_BITS];
    assign color_out    = c_mem[rd_ptr][int'(sel)*OUT_LANES*32 +: OUT_LANES*32];
    assign depth_out    = z_mem[rd_ptr][int'(sel)*OUT_LANES*ZBITS +: OUT_LANES*ZBITS];
    assign backface_out = bf_mem[rd_ptr][int'(sel)*OUT_LANES +: OUT_LANES];

    // Storage is intentionally not reset; occupancy tracking alone makes it safe.
    always_ff @(posedge clk) begin
        if (push) begin
            mask_mem[wr_ptr] <= tmask_in;
            x_mem[wr_ptr]    <= pos_x_in;
            y_mem[wr_ptr]    <= pos_y_in;
            c_mem[wr_ptr]    <= color_in;
            z_mem[wr_ptr]    <= depth_in;
            bf_mem[wr_ptr]   <= backface_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            grp_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (fire) grp_ptr <= last_out ? '0 : sel + 1'b1;
        end
    end

`ifdef ROP_FRAG_QUEUE_PERF_EN
    logic drop;
    assign drop = valid_in && ready_in && (tmask_in == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_stalls <= '0;
            perf_drops  <= '0;
        end else begin
            if (valid_in && !ready_in) perf_stalls <= perf_stalls + 32'd1;
            if (drop)                  perf_drops  <= perf_drops + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rop_frag_queue.sv
// Scoreboard bench for rop_frag_queue: stimulus pushes expected groups, a negedge monitor
// pops and compares them whenever an output group fires.
module tb_rop_frag_queue;

    localparam int NL = 4;
    localparam int DB = 11;
    localparam int ZB = 24;
    localparam int EW = 1 + DB + DB + 32 + ZB + 1 + 1;

    logic clk = 1'b0;
    logic reset, valid_in, ready_in, valid_out, ready_out, last_out;
    logic [NL-1:0]    tmask_in, backface_in;
    logic [NL*DB-1:0] pos_x_in, pos_y_in;
    logic [NL*32-1:0] color_in;
    logic [NL*ZB-1:0] depth_in;
    logic [0:0]       tmask_out, backface_out;
    logic [DB-1:0]    pos_x_out, pos_y_out;
    logic [31:0]      color_out;
    logic [ZB-1:0]    depth_out;
    logic [2:0]       count;
`ifdef ROP_FRAG_QUEUE_PERF_EN
    logic [31:0]      perf_stalls, perf_drops;
`endif

    int checks = 0;
    int errors = 0;
    int exp_stalls = 0;
    int exp_drops = 0;
    logic [EW-1:0] exp_q[$];

    rop_frag_queue dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
        .tmask_in(tmask_in), .pos_x_in(pos_x_in), .pos_y_in(pos_y_in),
        .color_in(color_in), .depth_in(depth_in), .backface_in(backface_in),
        .valid_out(valid_out), .ready_out(ready_out), .tmask_out(tmask_out),
        .pos_x_out(pos_x_out), .pos_y_out(pos_y_out), .color_out(color_out),
        .depth_out(depth_out), .backface_out(backface_out), .last_out(last_out),
`ifdef ROP_FRAG_QUEUE_PERF_EN
        .perf_stalls(perf_stalls), .perf_drops(perf_drops),
`endif
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-lane payload pattern for batch b
    function automatic logic [EW-2:0] lane_data(input int b, input int l);
        logic [DB-1:0] x, y;
        logic [31:0]   c;
        logic [ZB-1:0] z;
        x = DB'(b*16 + l);
        y = DB'(100 + b*4 + l);
        c = {8'(b), 8'(l), 16'hA5C3};
        z = ZB'(b*1000 + l);
        return {1'b1, x, y, c, z, 1'((b + l) % 2)};
    endfunction

    task automatic drive_batch(input int b, input logic [NL-1:0] m);
        tmask_in = m;
        for (int l = 0; l < NL; l++) begin
            logic [EW-2:0] d;
            d = lane_data(b, l);
            pos_x_in[l*DB +: DB]  = d[EW-3 -: DB];
            pos_y_in[l*DB +: DB]  = d[EW-3-DB -: DB];
            color_in[l*32 +: 32]  = d[EW-3-2*DB -: 32];
            depth_in[l*ZB +: ZB]  = d[ZB:1];
            backface_in[l]        = d[0];
        end
        valid_in = 1'b1;
    endtask

    // Expected output groups of one batch (OUT_LANES=1): one per set lane, last on the highest.
    task automatic push_exp(input int b, input logic [NL-1:0] m);
        for (int l = 0; l < NL; l++)
            if (m[l]) exp_q.push_back({lane_data(b, l), ((m >> (l + 1)) == 0)});
    endtask

    // Called just after a posedge; offers a batch until accepted or max cycles pass.
    task automatic offer(input int b, input logic [NL-1:0] m, input int max_cyc, output int stalls);
        bit acc = 0;
        int n = 0;
        stalls = 0;
        drive_batch(b, m);
        while (!acc && n < max_cyc) begin
            @(negedge clk);
            if (ready_in) begin
                acc = 1;
                if (m != 0) push_exp(b, m);
                else exp_drops++;
            end else begin
                stalls++;
                exp_stalls++;
            end
            @(posedge clk); #1;
            n++;
        end
        valid_in = 1'b0;
        chk($sformatf("accept_b%0d", b), 128'(acc), 128'(1));
    endtask

    task automatic drain(input string name, input int max_cyc);
        int n = 0;
        while ((exp_q.size() != 0 || valid_out) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk(name, 128'(n < max_cyc), 128'(1));
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && valid_out === 1'b1 && ready_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_group", 128'(1), 128'(0));
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                chk("group", 128'({tmask_out, pos_x_out, pos_y_out, color_out, depth_out,
                                    backface_out, last_out}), 128'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        reset = 1'b0; ready_out = 1'b0;
        drive_batch(0, 4'hF);

        // Reset held with a live full-mask batch offered
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            chk("rst_valid_out", 128'(valid_out), 128'(0));
            chk("rst_ready_in", 128'(ready_in), 128'(1));
            chk("rst_count", 128'(count), 128'(0));
        end
        valid_in = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst_count", 128'(count), 128'(0));
        chk("post_rst_valid", 128'(valid_out), 128'(0));
        @(posedge clk); #1;

        // Sparse mask 1010: lane1 (not last) then lane3 (last)
        ready_out = 1'b1;
        offer(1, 4'b1010, 5, st);
        drain("drain_sparse", 20);
        chk("sparse_count", 128'(count), 128'(0));
        chk("sparse_valid", 128'(valid_out), 128'(0));
        @(posedge clk); #1;

        // Zero mask: handshake, nothing stored
        offer(2, 4'b0000, 5, st);
        chk("drop_stalls", 128'(st), 128'(0));
        @(negedge clk);
        chk("drop_count", 128'(count), 128'(0));
        chk("drop_valid", 128'(valid_out), 128'(0));
`ifdef ROP_FRAG_QUEUE_PERF_EN
        chk("perf_drops", 128'(perf_drops), 128'(exp_drops));
`endif
        @(posedge clk); #1;

        // Fill with downstream stalled
        ready_out = 1'b0;
        for (int b = 3; b < 7; b++) begin
            offer(b, 4'hF, 5, st);
            chk("fill_stalls", 128'(st), 128'(0));
        end
        drive_batch(7, 4'hF);
        repeat (3) begin
            @(negedge clk);
            chk("full_ready_in", 128'(ready_in), 128'(0));
            chk("full_count", 128'(count), 128'(4));
            chk("full_valid", 128'(valid_out), 128'(1));
            exp_stalls++;
            @(posedge clk); #1;
        end

        // Release: four groups of the head go out before ready_in returns
        ready_out = 1'b1;
        offer(7, 4'hF, 20, st);
        chk("ready_in_rise", 128'(st), 128'(4));
`ifdef ROP_FRAG_QUEUE_PERF_EN
        @(negedge clk);
        chk("perf_stalls", 128'(perf_stalls), 128'(exp_stalls));
`endif
        drain("drain_full", 100);
        chk("drained_count", 128'(count), 128'(0));
        @(posedge clk); #1;

        // Reset while the head batch is partially issued
        ready_out = 1'b0;
        for (int b = 8; b < 11; b++) offer(b, 4'hF, 5, st);
        ready_out = 1'b1;
        repeat (2) begin
            @(negedge clk); @(posedge clk); #1;
        end
        ready_out = 1'b0; reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("pre_rst_count", 128'(count), 128'(3));
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_count", 128'(count), 128'(0));
        chk("mid_rst_valid", 128'(valid_out), 128'(0));
        chk("mid_rst_ready", 128'(ready_in), 128'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        ready_out = 1'b1;
        offer(11, 4'b0001, 5, st);
        drain("drain_after_rst", 20);
        chk("final_count", 128'(count), 128'(0));
        chk("final_queue", 128'(exp_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
